// File: rtl/solver_pixel_streamer.sv
// Raster-scans a frame, reads escape counts from the interleaved solver RAMs,
// maps them through a palette to RGB565 and streams an Avalon-ST video packet.
module solver_pixel_streamer #(
  parameter int unsigned NUM_SOLVERS = 29,
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned ITER_BITS   = 4,
  parameter int unsigned ID_BITS     = 6,
  parameter int unsigned ADDR_BITS   = 19,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 continuous,
  input  logic [1:0]           palette_mode,
  output logic [ID_BITS-1:0]   rd_solver_id,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [ITER_BITS-1:0] rd_data,
  input  logic                 st_ready,
  output logic                 st_valid,
  output logic [15:0]          st_data,
  output logic                 st_sop,
  output logic                 st_eop,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int unsigned NUM_PIX  = WIDTH * HEIGHT;
  localparam int unsigned PIX_BITS = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int unsigned PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAT_BITS = $clog2(RD_LATENCY + 1);
  localparam int unsigned SUM_BITS = CNT_BITS + LAT_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t state, state_next;

  logic [PIX_BITS-1:0] pix;
  logic [1:0]          mode_q;

  // Sideband pipeline aligned with the RAM read latency; carries the frame's palette too.
  logic [RD_LATENCY-1:0]      sb_valid, sb_sop, sb_eop;
  logic [RD_LATENCY-1:0][1:0] sb_mode;

  logic [15:0]         mem_data [FIFO_DEPTH];
  logic                mem_sop  [FIFO_DEPTH];
  logic                mem_eop  [FIFO_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] fifo_count, count_next;

  logic [SUM_BITS-1:0] inflight, credit_used;
  logic issue, last_pix, last_id, push, pop, eop_pop;

  function automatic logic [15:0] palette(input logic [3:0] v, input logic [1:0] m);
    logic [4:0] r, b;
    logic [5:0] g;
    logic [3:0] inv;
    r   = '0;
    g   = '0;
    b   = '0;
    inv = 4'd15 - v;
    case (m)
      2'd0: begin
        r = {v, v[3]};
        g = {v, v[3:2]};
        b = {v, v[3]};
      end
      2'd1: begin
        if (!v[3]) begin
          g = {v[2:0], 3'b000};
        end else begin
          g = {inv[2:0], 3'b000};
          b = 5'd24;
        end
      end
      2'd2:    g = {v, 2'b00};
      default: r = 5'd31;
    endcase
    return {r, g, b};
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + SUM_BITS'(sb_valid[i]);
    end
    credit_used = SUM_BITS'(fifo_count) + inflight;
    issue       = (state == ISSUE) && (credit_used < SUM_BITS'(FIFO_DEPTH));
    last_pix    = (pix == PIX_BITS'(NUM_PIX - 1));
    last_id     = (rd_solver_id == ID_BITS'(NUM_SOLVERS - 1));
    push        = sb_valid[RD_LATENCY-1];
    pop         = st_valid && st_ready;
    eop_pop     = pop && st_eop;
    case ({push, pop})
      2'b10:   count_next = fifo_count + CNT_BITS'(1);
      2'b01:   count_next = fifo_count - CNT_BITS'(1);
      default: count_next = fifo_count;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = ISSUE;
      ISSUE:   if (issue && last_pix && !continuous) state_next = DRAIN;
      DRAIN:   if (eop_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign st_data = mem_data[rd_ptr];
  assign st_sop  = mem_sop[rd_ptr];
  assign st_eop  = mem_eop[rd_ptr];

  // Read issue counters, sideband pipeline, output FIFO and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      pix          <= '0;
      rd_solver_id <= '0;
      rd_addr      <= '0;
      mode_q       <= '0;
      sb_valid     <= '0;
      sb_sop       <= '0;
      sb_eop       <= '0;
      sb_mode      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      st_valid     <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_sop[i]  <= 1'b0;
        mem_eop[i]  <= 1'b0;
      end
    end else begin
      if ((state == IDLE && run) || (issue && last_pix && continuous)) mode_q <= palette_mode;

      if (state == IDLE && run) begin
        pix          <= '0;
        rd_solver_id <= '0;
        rd_addr      <= '0;
      end else if (issue) begin
        if (last_pix) begin
          pix          <= '0;
          rd_solver_id <= '0;
          rd_addr      <= '0;
        end else begin
          pix <= pix + PIX_BITS'(1);
          if (last_id) begin
            rd_solver_id <= '0;
            rd_addr      <= rd_addr + ADDR_BITS'(1);
          end else begin
            rd_solver_id <= rd_solver_id + ID_BITS'(1);
          end
        end
      end

      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_sop[i]   <= sb_sop[i-1];
        sb_eop[i]   <= sb_eop[i-1];
        sb_mode[i]  <= sb_mode[i-1];
      end
      sb_valid[0] <= issue;
      sb_sop[0]   <= (pix == '0);
      sb_eop[0]   <= last_pix;
      sb_mode[0]  <= mode_q;

      if (push) begin
        mem_data[wr_ptr] <= palette(rd_data[ITER_BITS-1 -: 4], sb_mode[RD_LATENCY-1]);
        mem_sop[wr_ptr]  <= sb_sop[RD_LATENCY-1];
        mem_eop[wr_ptr]  <= sb_eop[RD_LATENCY-1];
        wr_ptr           <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_BITS'(1);
      fifo_count <= count_next;
      st_valid   <= (count_next != '0);
      frame_done <= eop_pop;
      busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_solver_pixel_streamer.sv
// Scoreboard bench for solver_pixel_streamer on a 4x2 frame with 3 interleaved solvers.
module tb_solver_pixel_streamer;

  localparam int unsigned NS    = 3;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned LAT   = 2;
  localparam int unsigned IB    = 4;
  localparam int unsigned IDB   = 6;
  localparam int unsigned AB    = 19;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NPIX  = W * H;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset, run, continuous, st_ready;
  logic [1:0]     palette_mode;
  logic [IDB-1:0] rd_solver_id;
  logic [AB-1:0]  rd_addr;
  logic [IB-1:0]  rd_data, ram_d1;
  logic           st_valid, st_sop, st_eop, frame_done, busy;
  logic [15:0]    st_data;

  logic [3:0] pix_mem [NPIX];
  beat_t      sb_q [$];
  int         checks = 0, errors = 0;
  int         cyc = 0, start_cyc = 0, first_cyc = 0, last_cyc = 0;
  int         beat_count = 0, done_count = 0;
  logic [15:0] got_data [32];
  logic        busy_at_done [4];
  logic        exp_done = 1'b0, prev_stall = 1'b0, prev_sop, prev_eop;
  logic [15:0] prev_data;

  solver_pixel_streamer #(
    .NUM_SOLVERS(NS), .WIDTH(W), .HEIGHT(H), .RD_LATENCY(LAT), .ITER_BITS(IB),
    .ID_BITS(IDB), .ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clk), .reset(reset), .run(run), .continuous(continuous),
    .palette_mode(palette_mode), .rd_solver_id(rd_solver_id), .rd_addr(rd_addr),
    .rd_data(rd_data), .st_ready(st_ready), .st_valid(st_valid), .st_data(st_data),
    .st_sop(st_sop), .st_eop(st_eop), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [3:0] ram_lookup(input logic [IDB-1:0] id, input logic [AB-1:0] a);
    int p;
    p = int'(a) * NS + int'(id);
    if (p < NPIX) return pix_mem[p];
    return 4'd0;
  endfunction

  // Solver RAM with a two-cycle read latency
  always @(posedge clk) begin
    ram_d1  <= ram_lookup(rd_solver_id, rd_addr);
    rd_data <= ram_d1;
  end

  function automatic logic [15:0] model(input int v, input int m);
    int r, g, b;
    r = 0; g = 0; b = 0;
    if (m == 0) begin
      r = v * 2 + v / 8; g = v * 4 + v / 4; b = r;
    end else if (m == 1) begin
      if (v < 8) g = v * 8;
      else begin g = (15 - v) * 8; b = 24; end
    end else if (m == 2) begin
      g = v * 4;
    end else begin
      r = 31;
    end
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  // Output monitor: pops the scoreboard on every accepted beat
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (frame_done || exp_done) begin
        checks++;
        if (frame_done !== exp_done) begin
          errors++;
          $display("FAIL frame_done: got %b expected %b at cycle %0d", frame_done, exp_done, cyc);
        end
      end
      if (frame_done) begin
        if (done_count < 4) busy_at_done[done_count] = busy;
        done_count++;
      end
      if (prev_stall) begin
        checks++;
        if (st_valid !== 1'b1 || st_data !== prev_data || st_sop !== prev_sop || st_eop !== prev_eop) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", st_valid, st_data, prev_data);
        end
      end
      exp_done = 1'b0;
      if (st_valid && st_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h sop=%b eop=%b with empty scoreboard", st_data, st_sop, st_eop);
        end else begin
          e = sb_q.pop_front();
          if (st_data !== e.data || st_sop !== e.sop || st_eop !== e.eop) begin
            errors++;
            $display("FAIL beat %0d: got d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                     beat_count, st_data, st_sop, st_eop, e.data, e.sop, e.eop);
          end
        end
        if (beat_count < 32) got_data[beat_count] = st_data;
        if (beat_count == 0) first_cyc = cyc;
        last_cyc = cyc;
        beat_count++;
        if (st_eop) exp_done = 1'b1;
      end
      prev_stall = st_valid && !st_ready;
      prev_data  = st_data;
      prev_sop   = st_sop;
      prev_eop   = st_eop;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int mode);
    beat_t b;
    for (int p = 0; p < NPIX; p++) begin
      b.data = model(int'(pix_mem[p]), mode);
      b.sop  = (p == 0);
      b.eop  = (p == NPIX - 1);
      sb_q.push_back(b);
    end
  endtask

  task automatic start_frame(input logic [1:0] mode);
    push_expected(int'(mode));
    palette_mode = mode;
    beat_count   = 0;
    done_count   = 0;
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_frames(input int n, input int ready_mode, input logic check_credit);
    int c;
    c = 0;
    while (c < 400) begin
      tick();
      if (done_count >= n) break;
      st_ready = (ready_mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (check_credit) begin
        checks++;
        if (int'(dut.fifo_count) + $countones(dut.sb_valid) > DEPTH) begin
          errors++;
          $display("FAIL credit: got fifo=%0d inflight=%0d limit %0d", dut.fifo_count, $countones(dut.sb_valid), DEPTH);
        end
      end
      c++;
    end
    st_ready = 1'b1;
    checks++;
    if (done_count != n) begin
      errors++;
      $display("FAIL frame_count: got %0d frame_done pulses expected %0d", done_count, n);
    end
    checks++;
    if (busy_at_done[n-1] !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got %b/%b expected 0", busy_at_done[n-1], busy);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d beats outstanding expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (st_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || st_sop !== 1'b0 || st_eop !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b busy=%b done=%b sop=%b eop=%b expected all 0", st_valid, busy, frame_done, st_sop, st_eop);
    end
    checks++;
    if (st_data !== 16'h0 || rd_solver_id !== '0 || rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: got d=%h id=%0d addr=%0d expected 0", st_data, rd_solver_id, rd_addr);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int p = 0; p < NPIX; p++) pix_mem[p] = 4'((p * 7 + 5) % 16);
    start_frame(2'd0);
    for (int k = 0; k < NPIX; k++) begin
      @(negedge clk);
      checks++;
      if (rd_solver_id !== IDB'(k % NS) || rd_addr !== AB'(k / NS)) begin
        errors++;
        $display("FAIL read_order %0d: got (%0d,%0d) expected (%0d,%0d)", k, rd_solver_id, rd_addr, k % NS, k / NS);
      end
    end
    wait_frames(1, 0, 1'b0);
    checks++;
    if (first_cyc - start_cyc != LAT + 1) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d", first_cyc - start_cyc, LAT + 1);
    end
    checks++;
    if (beat_count != NPIX || last_cyc - first_cyc != NPIX - 1) begin
      errors++;
      $display("FAIL throughput: got %0d beats over %0d cycles expected %0d over %0d", beat_count, last_cyc - first_cyc, NPIX, NPIX - 1);
    end
  endtask

  task automatic test_stall();
    for (int p = 0; p < NPIX; p++) pix_mem[p] = 4'($urandom_range(0, 15));
    start_frame(2'd2);
    wait_frames(1, 1, 1'b1);
    checks++;
    if (beat_count != NPIX) begin
      errors++;
      $display("FAIL stall_beats: got %0d expected %0d", beat_count, NPIX);
    end
  endtask

  task automatic test_palette();
    for (int p = 0; p < NPIX; p++) pix_mem[p] = 4'(p);
    start_frame(2'd1);
    repeat (3) tick();
    palette_mode = 2'd3;
    wait_frames(1, 0, 1'b0);
    checks++;
    if (got_data[3] !== 16'h0300) begin
      errors++;
      $display("FAIL palette_v3: got %h expected 0300", got_data[3]);
    end
    for (int p = 0; p < NPIX; p++) pix_mem[p] = 4'(p + 8);
    start_frame(2'd1);
    wait_frames(1, 0, 1'b0);
    checks++;
    if (got_data[7] !== 16'h0018) begin
      errors++;
      $display("FAIL palette_v15: got %h expected 0018", got_data[7]);
    end
    start_frame(2'd3);
    wait_frames(1, 0, 1'b0);
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (got_data[k] !== 16'hF800) begin
        errors++;
        $display("FAIL palette_red %0d: got %h expected F800", k, got_data[k]);
      end
    end
  endtask

  task automatic test_continuous();
    for (int p = 0; p < NPIX; p++) pix_mem[p] = 4'(15 - p);
    continuous = 1'b1;
    start_frame(2'd0);
    push_expected(2);
    repeat (4) tick();
    palette_mode = 2'd2;
    repeat (6) tick();
    continuous = 1'b0;
    wait_frames(2, 0, 1'b0);
    checks++;
    if (busy_at_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL cont_busy: got %b at first frame_done expected 1", busy_at_done[0]);
    end
    checks++;
    if (beat_count != 2 * NPIX || last_cyc - first_cyc != 2 * NPIX - 1) begin
      errors++;
      $display("FAIL cont_gap: got %0d beats over %0d cycles expected %0d over %0d", beat_count, last_cyc - first_cyc, 2 * NPIX, 2 * NPIX - 1);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    for (int p = 0; p < NPIX; p++) pix_mem[p] = 4'($urandom_range(0, 15));
    start_frame(2'd0);
    c = 0;
    while (beat_count < 5 && c < 50) begin
      @(negedge clk);
      c++;
    end
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (st_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b busy=%b done=%b expected 0", st_valid, busy, frame_done);
    end
    checks++;
    if (dut.fifo_count !== '0 || dut.sb_valid !== '0) begin
      errors++;
      $display("FAIL mid_reset_empty: got fifo=%0d sb=%b expected 0", dut.fifo_count, dut.sb_valid);
    end
    tick();
    reset = 1'b0;
    sb_q.delete();
    start_frame(2'd1);
    @(negedge clk);
    checks++;
    if (rd_solver_id !== '0 || rd_addr !== '0) begin
      errors++;
      $display("FAIL restart_addr: got (%0d,%0d) expected (0,0)", rd_solver_id, rd_addr);
    end
    wait_frames(1, 0, 1'b0);
  endtask

  task automatic test_stall_start();
    for (int p = 0; p < NPIX; p++) pix_mem[p] = 4'($urandom_range(0, 15));
    st_ready = 1'b0;
    start_frame(2'd0);
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (int'(rd_addr) * NS + int'(rd_solver_id) != DEPTH || beat_count != 0) begin
      errors++;
      $display("FAIL stall_issue: got %0d reads, %0d beats expected %0d reads, 0 beats",
               int'(rd_addr) * NS + int'(rd_solver_id), beat_count, DEPTH);
    end
    checks++;
    if (st_valid !== 1'b1 || dut.fifo_count !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL stall_full: got v=%b fifo=%0d expected v=1 fifo=%0d", st_valid, dut.fifo_count, DEPTH);
    end
    wait_frames(1, 0, 1'b0);
    checks++;
    if (beat_count != NPIX || last_cyc - first_cyc != NPIX - 1) begin
      errors++;
      $display("FAIL stall_drain: got %0d beats over %0d cycles expected %0d over %0d", beat_count, last_cyc - first_cyc, NPIX, NPIX - 1);
    end
  endtask

  initial begin
    reset        = 1'b1;
    run          = 1'b0;
    continuous   = 1'b0;
    palette_mode = 2'd0;
    st_ready     = 1'b1;
    for (int p = 0; p < NPIX; p++) pix_mem[p] = 4'd0;
    for (int i = 0; i < 4; i++) busy_at_done[i] = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_palette();
    test_continuous();
    test_reset_mid();
    test_stall_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
